// File: rtl/regfile_param_if.sv
// Register-file access bundle: two read ports, one byte-masked write port, clear control.
// Latency: none, pure signal grouping.
// Backpressure: busy tells the requester that writes are being dropped and reads return 0.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0]   rd_addr1;
   logic [ADDR_W-1:0]   rd_addr2;
   logic [DATA_W-1:0]   rd_data1;
   logic [DATA_W-1:0]   rd_data2;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W/8-1:0] wr_be;
   logic                clear_req;
   logic                busy;

   // Requester side (decode stage).
   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_be, clear_req,
      input  rd_data1, rd_data2, busy
   );

   // Register-file side.
   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_be, clear_req,
      output rd_data1, rd_data2, busy
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: 2 async read ports, 1 byte-masked sync write port, hardware clear.
// Latency: reads combinational (optional same-cycle write bypass); writes land on the next edge.
// Backpressure: busy high for DEPTH edges after reset/clear_req; writes dropped, reads 0 meanwhile.
module regfile_param #(
   parameter int DATA_W   = 32,  // multiple of 8
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic            clk,
   input  logic            rstd,
   regfile_param_if.slave  rf
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              busyQ;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              userWr;
   logic              fwdOk;
   logic [ADDR_W-1:0] rdAddr [2];
   logic [DATA_W-1:0] rdData [2];

   // A clear request outranks a write in the same cycle; writes to a hardwired r0 vanish.
   assign userWr = (state == IDLE) && !rf.clear_req && rf.wr_en &&
                   !((ZERO_REG != 0) && (rf.wr_addr == '0));
   // Forwarding only applies to a write that will really commit on this edge.
   assign fwdOk  = (BYPASS != 0) && (state == IDLE) && !rf.clear_req && rf.wr_en;

   assign rdAddr[0]   = rf.rd_addr1;
   assign rdAddr[1]   = rf.rd_addr2;
   assign rf.rd_data1 = rdData[0];
   assign rf.rd_data2 = rdData[1];
   assign rf.busy     = busyQ;

   // Clear sequencer: walk ptr over every entry, leave at DEPTH-1 so ptr never wraps.
   always_ff @(posedge clk or posedge rstd) begin
      if (rstd) begin
         state <= CLEAR;
         ptr   <= '0;
         busyQ <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (ptr == '1) begin
                  state <= IDLE;
                  busyQ <= 1'b0;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            IDLE: begin
               if (rf.clear_req) begin
                  state <= CLEAR;
                  busyQ <= 1'b1;
                  ptr   <= '0;
               end
            end
            default: begin
               state <= CLEAR;
               busyQ <= 1'b1;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Storage update: clear writes zero at ptr, otherwise merge enabled bytes of the user write.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[ptr] <= '0;
      end else if (userWr) begin
         for (int b = 0; b < NB; b++) begin
            if (rf.wr_be[b]) begin
               mem[rf.wr_addr][8*b +: 8] <= rf.wr_data[8*b +: 8];
            end
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : gRead
      // Read mux: stored word, overlaid with forwarded bytes, forced to 0 while clearing or for r0.
      always_comb begin
         rdData[p] = mem[rdAddr[p]];
         if (fwdOk && (rf.wr_addr == rdAddr[p])) begin
            for (int b = 0; b < NB; b++) begin
               if (rf.wr_be[b]) begin
                  rdData[p][8*b +: 8] = rf.wr_data[8*b +: 8];
               end
            end
         end
         if ((state != IDLE) || ((ZERO_REG != 0) && (rdAddr[p] == '0))) begin
            rdData[p] = '0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: variant A (zero reg + bypass) and variant B (neither) driven in lockstep.
// Expectations come from a word-array model with a clear countdown, updated once per edge.
module tb_regfile_param;
   logic clk;
   logic rstd;

   logic [4:0]  rdAddr1, rdAddr2, wrAddr;
   logic [31:0] wrData;
   logic [3:0]  wrBe;
   logic        wrEn, clearReq;

   int compared   = 0;
   int mismatched = 0;

   // Model: per-variant contents, plus the number of busy edges still to come.
   logic [31:0] refMem [2][32];
   int          clearLeft = 32;

   regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifA ();
   regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifB ();

   assign ifA.rd_addr1  = rdAddr1;
   assign ifA.rd_addr2  = rdAddr2;
   assign ifA.wr_en     = wrEn;
   assign ifA.wr_addr   = wrAddr;
   assign ifA.wr_data   = wrData;
   assign ifA.wr_be     = wrBe;
   assign ifA.clear_req = clearReq;
   assign ifB.rd_addr1  = rdAddr1;
   assign ifB.rd_addr2  = rdAddr2;
   assign ifB.wr_en     = wrEn;
   assign ifB.wr_addr   = wrAddr;
   assign ifB.wr_data   = wrData;
   assign ifB.wr_be     = wrBe;
   assign ifB.clear_req = clearReq;

   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dutA (
      .clk(clk), .rstd(rstd), .rf(ifA.slave));
   regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dutB (
      .clk(clk), .rstd(rstd), .rf(ifB.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // v=0: zero reg + bypass; v=1: plain register file.
   function automatic logic [31:0] expRd(input int v, input logic [4:0] a);
      logic [31:0] d;
      if (rstd || clearLeft > 0) return 32'h0;
      if (v == 0 && a == 5'd0) return 32'h0;
      d = refMem[v][a];
      if (v == 0 && wrEn && !clearReq && a == wrAddr) begin
         for (int b = 0; b < 4; b++) if (wrBe[b]) d[8*b +: 8] = wrData[8*b +: 8];
      end
      return d;
   endfunction

   function automatic logic expBusy();
      return rstd || (clearLeft > 0);
   endfunction

   task automatic zeroModel();
      for (int v = 0; v < 2; v++) for (int a = 0; a < 32; a++) refMem[v][a] = 32'h0;
   endtask

   task automatic modelEdge();
      if (rstd) begin
         clearLeft = 32;
         zeroModel();
      end else if (clearLeft > 0) begin
         clearLeft--;
      end else if (clearReq) begin
         clearLeft = 32;
         zeroModel();
      end else if (wrEn) begin
         for (int v = 0; v < 2; v++) begin
            if (!(v == 0 && wrAddr == 5'd0)) begin
               for (int b = 0; b < 4; b++)
                  if (wrBe[b]) refMem[v][wrAddr][8*b +: 8] = wrData[8*b +: 8];
            end
         end
      end
   endtask

   task automatic checkAll(input string tag);
      chk({tag, ".A.rd1"}, ifA.rd_data1, expRd(0, rdAddr1));
      chk({tag, ".A.rd2"}, ifA.rd_data2, expRd(0, rdAddr2));
      chk({tag, ".B.rd1"}, ifB.rd_data1, expRd(1, rdAddr1));
      chk({tag, ".B.rd2"}, ifB.rd_data2, expRd(1, rdAddr2));
      chk({tag, ".A.busy"}, {31'b0, ifA.busy}, {31'b0, expBusy()});
      chk({tag, ".B.busy"}, {31'b0, ifB.busy}, {31'b0, expBusy()});
   endtask

   // Inputs already set: check the combinational view, take one edge, advance the model.
   task automatic step(input string tag);
      #1;
      checkAll(tag);
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic idleIn();
      wrEn = 1'b0; clearReq = 1'b0; wrBe = 4'h0; wrData = 32'h0; wrAddr = 5'd0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      idleIn();
      wrEn = 1'b1; wrAddr = a; wrData = d; wrBe = be;
      step("wr");
      idleIn();
   endtask

   // Count edges while busy (bounded); busy must last exactly 32 edges.
   task automatic countBusy(input string tag, input bit junkWrites);
      int n = 0;
      for (int i = 0; i < 40 && ifA.busy; i++) begin
         if (junkWrites) begin
            wrEn = 1'b1; wrAddr = 5'($urandom); wrData = $urandom; wrBe = 4'hF;
         end
         n++;
         step(tag);
      end
      idleIn();
      chk({tag, ".busyEdges"}, 32'(n), 32'd32);
   endtask

   task automatic readAllZero(input string tag);
      for (int a = 0; a < 32; a++) begin
         rdAddr1 = 5'(a); rdAddr2 = 5'(31 - a);
         #1;
         chk({tag, ".A"}, ifA.rd_data1, 32'h0);
         chk({tag, ".B"}, ifB.rd_data1, 32'h0);
         step(tag);
      end
   endtask

   initial begin
      zeroModel();
      idleIn();
      rdAddr1 = 5'd3; rdAddr2 = 5'd9;
      rstd = 1'b1;

      // Reset and release.
      step("rst"); step("rst"); step("rst");
      rstd = 1'b0;
      countBusy("relBusy", 1'b0);
      readAllZero("relZero");

      // Full and partial byte writes.
      wr(5'd5, 32'hDEADBEEF, 4'hF);
      rdAddr1 = 5'd5; rdAddr2 = 5'd5;
      #1;
      chk("basic.A", ifA.rd_data1, 32'hDEADBEEF);
      chk("basic.B", ifB.rd_data2, 32'hDEADBEEF);
      step("basic");
      wr(5'd5, 32'h11223344, 4'b0101);
      #1;
      chk("bytes.A", ifA.rd_data1, 32'hDE22BE44);
      chk("bytes.B", ifB.rd_data1, 32'hDE22BE44);
      step("bytes");
      wr(5'd5, 32'h99999999, 4'h0);
      step("noBe");

      // Zero register.
      wr(5'd0, 32'hFFFFFFFF, 4'hF);
      rdAddr1 = 5'd0;
      #1;
      chk("zero.A", ifA.rd_data1, 32'h0);
      chk("zero.B", ifB.rd_data1, 32'hFFFFFFFF);
      step("zero");

      // Bypass.
      wr(5'd7, 32'hAAAAAAAA, 4'hF);
      wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'h12345678; wrBe = 4'b0011;
      rdAddr1 = 5'd7; rdAddr2 = 5'd7;
      #1;
      chk("byp.A1", ifA.rd_data1, 32'hAAAA5678);
      chk("byp.A2", ifA.rd_data2, 32'hAAAA5678);
      chk("byp.B1", ifB.rd_data1, 32'hAAAAAAAA);
      chk("byp.B2", ifB.rd_data2, 32'hAAAAAAAA);
      step("byp");
      idleIn();
      step("bypAfter");

      // Clear request with a competing write, then junk writes during busy.
      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i), 4'hF);
      clearReq = 1'b1; wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'h55; wrBe = 4'hF;
      rdAddr1 = 5'd3;
      step("clrReq");
      idleIn();
      countBusy("clrBusy", 1'b1);
      readAllZero("clrZero");

      // Reset in the middle of a clear.
      wr(5'd12, 32'hCAFEF00D, 4'hF);
      clearReq = 1'b1;
      step("clr2");
      idleIn();
      for (int i = 0; i < 10; i++) step("clr2run");
      rstd = 1'b1;
      step("midRst"); step("midRst");
      rstd = 1'b0;
      countBusy("midBusy", 1'b1);
      readAllZero("midZero");

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         wrEn     = 1'($urandom);
         wrAddr   = 5'($urandom);
         wrData   = $urandom;
         wrBe     = 4'($urandom);
         clearReq = ($urandom_range(0, 79) == 0);
         rdAddr1  = ($urandom_range(0, 2) == 0) ? wrAddr : 5'($urandom);
         rdAddr2  = ($urandom_range(0, 2) == 0) ? wrAddr : 5'($urandom);
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Configurable data width and depth, two asynchronous read ports and one synchronous write port with byte enables.
- Optional hardwired zero register and optional write-to-read bypass.
- A hardware clear sequencer zeroes every entry after reset or on request, so the array never holds X values. Sits in the decode stage between instruction decode and the ALU operand muxes.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register.
- BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports; 0: reads return stored contents only.

Ports:
- clk  input  1  rising-edge clock.
- rstd  input  1  asynchronous reset, active-high.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data.
- rd_data2  output  DATA_W  read port 2 data.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- clear_req  input  1  one-cycle pulse requesting a full clear.
- busy  output  1  high while the clear sequencer runs.

Behaviour:
- Interface (decided): one clock, clk; reset rstd is asynchronous and active-high.

FSM states:
- CLEAR: clear sequencer running.
- IDLE: normal operation.

Reset:
- While rstd=1: state=CLEAR, clear pointer=0, busy=1.
- rd_data1/rd_data2 read 0 regardless of address.

CLEAR state:
- Each rising edge writes 0 to mem[ptr], then ptr <= ptr+1.
- When ptr==DEPTH-1 the edge that writes that entry also moves the FSM to IDLE.
- busy therefore stays high for exactly DEPTH rising edges after rstd falls, and is 0 from the following cycle.
- User writes (wr_en) are dropped.
- All reads return 0.
- clear_req is ignored; the clear does not restart.
- rstd asserted mid-clear: the pointer resets to 0 and the clear restarts from entry 0.

IDLE state:
- clear_req=1: next edge enters CLEAR with ptr=0. clear_req has priority, so a write in the same cycle is dropped.
- Write: if wr_en=1 and clear_req=0, on the rising edge each byte i with wr_be[i]=1 is updated; other bytes are kept.
- wr_be all zero means no change.
- ZERO_REG=1 and wr_addr=0: write dropped.

Read (combinational, no latency):
- rd_dataN = mem[rd_addrN].
- ZERO_REG=1 and rd_addrN=0: result is 0, with no bypass.
- BYPASS=1, wr_en=1, state IDLE, clear_req=0, wr_addr==rd_addrN: bytes with wr_be set come from wr_data; the other bytes come from mem. The result equals the post-edge contents.
- Both read ports may address the same entry; each is resolved independently.

Widths and ranges:
- No arithmetic beyond the pointer increment.
- The pointer is ADDR_W bits and never wraps in use, because the exit is taken at DEPTH-1.

Test Plan:
- Reset release: pulse rstd, then count cycles -> busy high for exactly 32 edges; afterwards every address reads 0x00000000.
- Basic write: write 0xDEADBEEF to r5 with wr_be=4'hF -> next cycle rd_addr1=5 gives 0xDEADBEEF. Write 0x11223344 to r5 with wr_be=4'b0101 -> r5 reads 0xDE22BE44.
- Zero register: write 0xFFFFFFFF to r0 -> r0 reads 0. With ZERO_REG=0, r0 reads 0xFFFFFFFF.
- Bypass: r7=0xAAAAAAAA; in the same cycle set wr_en=1, wr_addr=7, wr_data=0x12345678, wr_be=4'b0011, rd_addr1=rd_addr2=7 -> both ports show 0xAAAA5678 before the edge. With BYPASS=0 they show 0xAAAAAAAA.
- Clear request: fill r1..r31 with index values, then pulse clear_req together with a write of 0x55 to r3 -> busy for 32 cycles, write dropped; afterwards all entries read 0. Writes issued during busy are lost.
- Reset mid-clear: assert rstd at clear cycle 10 -> busy stays high and the count restarts; 32 edges after release, busy=0 and all entries read 0.
